miriscv_lsu: RTL and testbench



---
 rtl/miriscv_lsu.sv | 156 +++++++++++++++
 tb/tb_miriscv_lsu.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : miriscv_lsu
// Description : Load/store unit. Runs a req/gnt/rvalid transaction on the
//               data bus, stalls the core until the access completes, and
//               returns sign/zero-extended load data.
// Revision    : 1.0 - initial release
// ============================================================================
module miriscv_lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic        lsu_stall_req_o,
    output logic [31:0] lsu_data_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    localparam logic [2:0] c_LDST_B  = 3'd0;
    localparam logic [2:0] c_LDST_H  = 3'd1;
    localparam logic [2:0] c_LDST_W  = 3'd2;
    localparam logic [2:0] c_LDST_BU = 3'd4;
    localparam logic [2:0] c_LDST_HU = 3'd5;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_REQ     = 2'd1;
    localparam logic [1:0] c_WAIT_RV = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    logic [1:0]  r_state;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_ldata;
    logic [2:0]  r_size;
    logic [1:0]  r_off;

    logic        w_err;
    logic        w_err_idle;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_ldata;

    // Alignment / size legality of the incoming request
    always_comb begin
        w_err = 1'b0;
        case (lsu_size_i)
            c_LDST_B, c_LDST_BU: w_err = 1'b0;
            c_LDST_H, c_LDST_HU: w_err = lsu_addr_i[0];
            c_LDST_W:            w_err = |lsu_addr_i[1:0];
            default:             w_err = 1'b1;
        endcase
    end

    // Errors only matter while a new request is being accepted
    assign w_err_idle      = (r_state == c_IDLE) & w_err;
    assign lsu_err_o       = lsu_req_i & w_err_idle;
    assign lsu_stall_req_o = lsu_req_i & ~w_err_idle & (r_state != c_DONE);

    // Byte enables and lane-replicated store data for the incoming request
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = lsu_data_i;
        case (lsu_size_i)
            c_LDST_B, c_LDST_BU: begin
                w_be    = 4'b0001 << lsu_addr_i[1:0];
                w_wdata = {4{lsu_data_i[7:0]}};
            end
            c_LDST_H, c_LDST_HU: begin
                w_be    = 4'b0011 << lsu_addr_i[1:0];
                w_wdata = {2{lsu_data_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = lsu_data_i;
            end
        endcase
    end

    // Align the addressed lane to bit 0 and extend according to the size
    assign w_shifted = data_rdata_i >> {r_off, 3'b000};

    always_comb begin
        w_ldata = w_shifted;
        case (r_size)
            c_LDST_B:  w_ldata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_LDST_BU: w_ldata = {24'd0, w_shifted[7:0]};
            c_LDST_H:  w_ldata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_LDST_HU: w_ldata = {16'd0, w_shifted[15:0]};
            default:   w_ldata = w_shifted;
        endcase
    end

    // Transaction FSM; bus fields are latched on entry to REQ and held stable
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
            r_we    <= 1'b0;
            r_be    <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_ldata <= 32'd0;
            r_size  <= 3'd0;
            r_off   <= 2'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (lsu_req_i && !w_err) begin
                        r_state <= c_REQ;
                        r_we    <= lsu_we_i;
                        r_be    <= w_be;
                        r_addr  <= {lsu_addr_i[31:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_size  <= lsu_size_i;
                        r_off   <= lsu_addr_i[1:0];
                    end
                end
                c_REQ: begin
                    if (data_gnt_i) begin
                        r_state <= r_we ? c_DONE : c_WAIT_RV;
                    end
                end
                c_WAIT_RV: begin
                    if (data_rvalid_i) begin
                        r_ldata <= w_ldata;
                        r_state <= c_DONE;
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign data_req_o   = (r_state == c_REQ);
    assign data_we_o    = r_we;
    assign data_be_o    = r_be;
    assign data_addr_o  = r_addr;
    assign data_wdata_o = r_wdata;
    assign lsu_data_o   = r_ldata;

endmodule
`default_nettype wire

// File: tb/tb_miriscv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_miriscv_lsu
// Description : Self-checking bench for miriscv_lsu with a bus/load-data
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_miriscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic        lsu_stall_req_o;
    logic [31:0] lsu_data_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_wd;
    } bus_t;

    bus_t        bus_q[$];
    logic [31:0] load_q[$];

    miriscv_lsu dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_stall_req_o (lsu_stall_req_o),
        .lsu_data_o      (lsu_data_o),
        .lsu_err_o       (lsu_err_o),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_gnt_i      (data_gnt_i),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i)
    );

    // 100 MHz core clock
    always #5 clk_i = ~clk_i;

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One complete access: pushes expectations, drives the bus side, checks
    task automatic run_op(input logic we, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input int gnt_dly, input int rv_dly,
                          input logic [31:0] rd, input logic [31:0] exp_ld,
                          input int exp_stall, input string name);
        bus_t        b;
        bus_t        e;
        logic [31:0] el;
        int          stalls;
        stalls   = 0;
        b.we     = we;
        b.be     = exp_be;
        b.addr   = {addr[31:2], 2'b00};
        b.wdata  = exp_wd;
        b.chk_wd = we;
        bus_q.push_back(b);
        if (!we) load_q.push_back(exp_ld);

        lsu_req_i  = 1'b1;
        lsu_we_i   = we;
        lsu_size_i = size;
        lsu_addr_i = addr;
        lsu_data_i = wd;
        #1;
        total++;
        if (lsu_stall_req_o !== 1'b1 || data_req_o !== 1'b0 || lsu_err_o !== 1'b0)
            $display("FAIL %s_idle: stall=%b req=%b err=%b, expected stall=1 req=0 err=0",
                     name, lsu_stall_req_o, data_req_o, lsu_err_o);
        else passed++;
        if (lsu_stall_req_o === 1'b1) stalls++;
        step();

        for (int i = 0; i <= gnt_dly; i++) begin
            e = bus_q[0];
            total++;
            if (data_req_o !== 1'b1 || data_we_o !== e.we || data_be_o !== e.be ||
                data_addr_o !== e.addr || (e.chk_wd && data_wdata_o !== e.wdata))
                $display("FAIL %s_req%0d: req=%b we=%b be=%b addr=%h wdata=%h, expected req=1 we=%b be=%b addr=%h wdata=%h",
                         name, i, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
                         e.we, e.be, e.addr, e.wdata);
            else passed++;
            if (lsu_stall_req_o === 1'b1) stalls++;
            if (i == gnt_dly) begin
                data_gnt_i = 1'b1;
                if (!we) begin
                    // rvalid coincident with gnt must be ignored
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = ~rd;
                end
                e = bus_q.pop_front();
            end
            step();
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
        end

        if (!we) begin
            for (int j = 0; j <= rv_dly; j++) begin
                total++;
                if (data_req_o !== 1'b0 || lsu_stall_req_o !== 1'b1)
                    $display("FAIL %s_wait%0d: req=%b stall=%b, expected req=0 stall=1",
                             name, j, data_req_o, lsu_stall_req_o);
                else passed++;
                if (lsu_stall_req_o === 1'b1) stalls++;
                if (j == rv_dly) begin
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = rd;
                end
                step();
                data_rvalid_i = 1'b0;
            end
        end

        // DONE cycle: stall released, request still held by the core
        total++;
        if (lsu_stall_req_o !== 1'b0 || data_req_o !== 1'b0)
            $display("FAIL %s_done: stall=%b req=%b, expected stall=0 req=0",
                     name, lsu_stall_req_o, data_req_o);
        else passed++;
        if (!we) begin
            el = load_q.pop_front();
            total++;
            if (lsu_data_o !== el)
                $display("FAIL %s_data: got %h expected %h", name, lsu_data_o, el);
            else passed++;
        end
        step();

        // Back in IDLE: no new bus request, load result held
        total++;
        if (data_req_o !== 1'b0 || (!we && lsu_data_o !== exp_ld))
            $display("FAIL %s_after: req=%b data=%h, expected req=0 data=%h",
                     name, data_req_o, lsu_data_o, exp_ld);
        else passed++;
        total++;
        if (stalls !== exp_stall)
            $display("FAIL %s_stall_len: got %0d cycles expected %0d", name, stalls, exp_stall);
        else passed++;
        lsu_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        total++;
        if (data_req_o !== 1'b0 || data_we_o !== 1'b0 || data_be_o !== 4'd0 ||
            data_addr_o !== 32'd0 || data_wdata_o !== 32'd0 || lsu_data_o !== 32'd0)
            $display("FAIL reset_regs: req=%b we=%b be=%b addr=%h wdata=%h data=%h, expected all 0",
                     data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, lsu_data_o);
        else passed++;
        total++;
        if (lsu_stall_req_o !== 1'b0 || lsu_err_o !== 1'b0)
            $display("FAIL reset_comb: stall=%b err=%b, expected 0 0", lsu_stall_req_o, lsu_err_o);
        else passed++;
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_stores();
        run_op(1'b1, 3'd2, 32'h0000_0104, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0, 2, "sw");
        run_op(1'b1, 3'd0, 32'h0000_0203, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 0, 0, 32'h0, 32'h0, 2, "sb");
        run_op(1'b1, 3'd1, 32'h0000_0602, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, 1, 0, 32'h0, 32'h0, 3, "sh");
    endtask

    task automatic test_loads();
        run_op(1'b0, 3'd0, 32'h0000_0302, 32'h0, 4'b0100, 32'h0, 2, 0, 32'h12F0_3456, 32'hFFFF_FFF0, 5, "lb");
        run_op(1'b0, 3'd4, 32'h0000_0302, 32'h0, 4'b0100, 32'h0, 2, 0, 32'h12F0_3456, 32'h0000_00F0, 5, "lbu");
        run_op(1'b0, 3'd1, 32'h0000_0402, 32'h0, 4'b1100, 32'h0, 0, 0, 32'h8001_0000, 32'hFFFF_8001, 3, "lh");
        run_op(1'b0, 3'd5, 32'h0000_0402, 32'h0, 4'b1100, 32'h0, 0, 0, 32'h8001_0000, 32'h0000_8001, 3, "lhu");
        run_op(1'b0, 3'd2, 32'h0000_0500, 32'h0, 4'b1111, 32'h0, 1, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, 6, "lw");
    endtask

    task automatic test_back_to_back();
        run_op(1'b1, 3'd2, 32'h0000_0900, 32'h1122_3344, 4'b1111, 32'h1122_3344, 0, 0, 32'h0, 32'h0, 2, "b2b_sw");
        run_op(1'b0, 3'd5, 32'h0000_0906, 32'h0, 4'b1100, 32'h0, 0, 0, 32'hABCD_0000, 32'h0000_ABCD, 3, "b2b_lhu");
        run_op(1'b1, 3'd0, 32'h0000_0901, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A, 0, 0, 32'h0, 32'h0, 2, "b2b_sb");
    endtask

    task automatic test_err(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input string name);
        lsu_req_i  = 1'b1;
        lsu_we_i   = we;
        lsu_size_i = size;
        lsu_addr_i = addr;
        lsu_data_i = 32'h0;
        #1;
        total++;
        if (lsu_err_o !== 1'b1 || lsu_stall_req_o !== 1'b0 || data_req_o !== 1'b0)
            $display("FAIL %s: err=%b stall=%b req=%b, expected err=1 stall=0 req=0",
                     name, lsu_err_o, lsu_stall_req_o, data_req_o);
        else passed++;
        step();
        total++;
        if (data_req_o !== 1'b0 || lsu_err_o !== 1'b1)
            $display("FAIL %s_next: req=%b err=%b, expected req=0 err=1", name, data_req_o, lsu_err_o);
        else passed++;
        lsu_req_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_size_i = 3'd2;
        lsu_addr_i = 32'h0000_0800;
        lsu_data_i = 32'h0;
        step();
        data_gnt_i = 1'b1;
        step();
        data_gnt_i = 1'b0;
        total++;
        if (data_req_o !== 1'b0 || lsu_stall_req_o !== 1'b1 || lsu_data_o === 32'h0)
            $display("FAIL rstmid_wait: req=%b stall=%b data=%h, expected req=0 stall=1 data!=0",
                     data_req_o, lsu_stall_req_o, lsu_data_o);
        else passed++;
        rst_i = 1'b1;
        step();
        rst_i     = 1'b0;
        lsu_req_i = 1'b0;
        total++;
        if (data_req_o !== 1'b0 || lsu_data_o !== 32'h0 || data_be_o !== 4'd0)
            $display("FAIL rstmid_clear: req=%b data=%h be=%b, expected req=0 data=0 be=0",
                     data_req_o, lsu_data_o, data_be_o);
        else passed++;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hFFFF_FFFF;
        step();
        data_rvalid_i = 1'b0;
        total++;
        if (lsu_data_o !== 32'h0)
            $display("FAIL rstmid_late_rvalid: got %h expected 00000000", lsu_data_o);
        else passed++;
        // Error flag only appears in IDLE, so this confirms the state
        lsu_req_i  = 1'b1;
        lsu_size_i = 3'd3;
        lsu_addr_i = 32'h0000_0700;
        #1;
        total++;
        if (lsu_err_o !== 1'b1 || data_req_o !== 1'b0)
            $display("FAIL rstmid_idle: err=%b req=%b, expected err=1 req=0", lsu_err_o, data_req_o);
        else passed++;
        lsu_req_i = 1'b0;
        step();
    endtask

    initial begin
        rst_i         = 1'b1;
        lsu_req_i     = 1'b0;
        lsu_we_i      = 1'b0;
        lsu_size_i    = 3'd0;
        lsu_addr_i    = 32'h0;
        lsu_data_i    = 32'h0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;

        test_reset();
        test_stores();
        test_loads();
        test_back_to_back();
        test_err(1'b0, 3'd2, 32'h0000_0501, "err_lw");
        test_err(1'b1, 3'd1, 32'h0000_0601, "err_sh");
        test_err(1'b0, 3'd3, 32'h0000_0700, "err_size3");
        test_reset_mid();

        total++;
        if (bus_q.size() != 0 || load_q.size() != 0)
            $display("FAIL scoreboard_drain: bus=%0d load=%0d entries left, expected 0 0",
                     bus_q.size(), load_q.size());
        else passed++;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
